// File: rtl/ks_prefix_pipe_if.sv
// ks_prefix_pipe_if: handshake bundle for the pipelined Kogge-Stone prefix/sum stage.
//   Input side : in_valid, in_ready, g_in, p_in, cin
//   Output side: out_valid, out_ready, sum, cout (+ ovf when KS_OVF_EN is defined)
//   master -- drives operations in and consumes results (producer/consumer side)
//   slave  -- the prefix pipeline itself
interface ks_prefix_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] p_in;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef KS_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, g_in, p_in, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, g_in, p_in, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, g_in, p_in, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, g_in, p_in, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/ks_prefix_pipe.sv
// ks_prefix_pipe: pipelined Kogge-Stone prefix network plus sum stage.
//   Takes per-bit generate/propagate vectors and carry-in, produces registered
//   sum/cout after LEVELS+1 cycles behind a valid/ready handshake.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - ks_prefix_pipe_if.slave (in_valid/in_ready/g_in/p_in/cin,
//           out_valid/out_ready/sum/cout, ovf)
// Optional feature macro: KS_OVF_EN adds a registered signed-overflow output.
module ks_prefix_pipe #(
  parameter  int WIDTH  = 16,
  localparam int LEVELS = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  ks_prefix_pipe_if.slave bus
);

  localparam int unsigned HALF = WIDTH / 2;

  // Stage valids: v[0..LEVELS-1] hold prefix data, v[LEVELS] is the output register.
  logic [LEVELS:0]  v;
  logic [LEVELS:0]  adv;

  logic [WIDTH-1:0] g_q  [LEVELS];
  logic [WIDTH-1:0] p_q  [LEVELS];
  logic [WIDTH-1:0] po_q [LEVELS];
  logic [LEVELS-1:0] c_q;

  logic [WIDTH-1:0] g_nx [LEVELS];
  logic [WIDTH-1:0] p_nx [LEVELS];

  logic [WIDTH-1:0] c_fin;
  logic [WIDTH-1:0] sum_nx;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
`ifdef KS_OVF_EN
  logic             ovf_q;
`endif

  // A stage advances if out_ready is high or any stage from it to the output
  // is empty; this is the unrolled form of adv[k] = !v[k] | adv[k+1].
  always_comb begin
    logic full_run;
    adv      = '0;
    full_run = v[LEVELS];
    adv[LEVELS] = !full_run || bus.out_ready;
    for (int unsigned j = 0; j < LEVELS; j++) begin
      full_run = full_run && v[LEVELS-1-j];
      adv[LEVELS-1-j] = !full_run || bus.out_ready;
    end
  end

  // Next-stage prefix data. Bit 0 absorbs carry-in so every group generate
  // below is directly the carry out of its bit.
  always_comb begin
    int unsigned d;
    for (int unsigned k = 0; k < LEVELS; k++) begin
      g_nx[k] = '0;
      p_nx[k] = '0;
    end
    g_nx[0]    = bus.g_in;
    g_nx[0][0] = bus.g_in[0] | (bus.p_in[0] & bus.cin);
    p_nx[0]    = bus.p_in;
    for (int unsigned k = 1; k < LEVELS; k++) begin
      d = 32'd1 << (k - 1);
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (i < d) begin
          g_nx[k][i] = g_q[k-1][i];
          p_nx[k][i] = p_q[k-1][i];
        end else begin
          g_nx[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i-d]);
          p_nx[k][i] = p_q[k-1][i] & p_q[k-1][i-d];
        end
      end
    end
  end

  // Last prefix level only needs group generate; it feeds the sum directly.
  always_comb begin
    c_fin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i < HALF) begin
        c_fin[i] = g_q[LEVELS-1][i];
      end else begin
        c_fin[i] = g_q[LEVELS-1][i] | (p_q[LEVELS-1][i] & g_q[LEVELS-1][i-HALF]);
      end
    end
    sum_nx = po_q[LEVELS-1] ^ {c_fin[WIDTH-2:0], c_q[LEVELS-1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
      for (int unsigned k = 0; k < LEVELS; k++) begin
        g_q[k]  <= '0;
        p_q[k]  <= '0;
        po_q[k] <= '0;
      end
      c_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef KS_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      if (adv[0]) begin
        v[0]    <= bus.in_valid;
        g_q[0]  <= g_nx[0];
        p_q[0]  <= p_nx[0];
        po_q[0] <= bus.p_in;
        c_q[0]  <= bus.cin;
      end
      for (int unsigned k = 1; k < LEVELS; k++) begin
        if (adv[k]) begin
          v[k]    <= v[k-1];
          g_q[k]  <= g_nx[k];
          p_q[k]  <= p_nx[k];
          po_q[k] <= po_q[k-1];
          c_q[k]  <= c_q[k-1];
        end
      end
      if (adv[LEVELS]) begin
        v[LEVELS] <= v[LEVELS-1];
        sum_q     <= sum_nx;
        cout_q    <= c_fin[WIDTH-1];
`ifdef KS_OVF_EN
        ovf_q     <= c_fin[WIDTH-1] ^ c_fin[WIDTH-2];
`endif
      end
    end
  end

  assign bus.in_ready  = rst_n && adv[0];
  assign bus.out_valid = v[LEVELS];
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef KS_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_ks_prefix_pipe.sv
// tb_ks_prefix_pipe: directed bench for ks_prefix_pipe (WIDTH=16).
module tb_ks_prefix_pipe;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ks_prefix_pipe_if #(.WIDTH(W)) bus ();
  ks_prefix_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [15:0] g;
    logic [15:0] p;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t expq[$];

  logic [15:0] cur_a, cur_b;
  logic        cur_cin;
  bit          have_op = 1'b0;
  int          issued = 0, received = 0, step_no = 0, first_out = -1, last_out = -1;
  bit          prev_hold = 1'b0;
  logic [15:0] prev_sum;
  logic        prev_cout;
  bit          last_in_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
    exp_t r;
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b} + {16'b0, c};
    r.sum  = s[15:0];
    r.cout = s[16];
    r.ovf  = (a[15] == b[15]) && (s[15] != a[15]);
    return r;
  endfunction

  // One handshake cycle: drive, settle, score both sides, advance one edge.
  task automatic drive_step(input bit want_new, input bit rdy);
    bit   acc;
    exp_t e;
    if (!have_op && want_new) begin
      cur_a   = 16'($urandom);
      cur_b   = 16'($urandom);
      cur_cin = 1'($urandom_range(0, 1));
      have_op = 1'b1;
    end
    bus.in_valid  = have_op;
    bus.g_in      = cur_a & cur_b;
    bus.p_in      = cur_a ^ cur_b;
    bus.cin       = cur_cin;
    bus.out_ready = rdy;
    #1;
    last_in_ready = bus.in_ready;
    acc = have_op && bus.in_ready;
    if (acc) expq.push_back(model(cur_a, cur_b, cur_cin));
    if (prev_hold) begin
      checks++;
      if (!(bus.out_valid === 1'b1 && bus.sum === prev_sum && bus.cout === prev_cout)) begin
        errors++;
        $display("FAIL hold_stable: got valid=%0b sum=0x%0h cout=%0b expected valid=1 sum=0x%0h cout=%0b",
                 bus.out_valid, bus.sum, bus.cout, prev_sum, prev_cout);
      end
    end
    prev_hold = bus.out_valid && !bus.out_ready;
    prev_sum  = bus.sum;
    prev_cout = bus.cout;
    if (bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum=0x%0h with out_valid=1 expected no result", bus.sum);
      end else begin
        e = expq.pop_front();
        chk("stream_sum", 32'(bus.sum), 32'(e.sum));
        chk("stream_cout", 32'(bus.cout), 32'(e.cout));
`ifdef KS_OVF_EN
        chk("stream_ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
      end
      received++;
      if (first_out < 0) first_out = step_no;
      last_out = step_no;
    end
    step_no++;
    @(posedge clk); #1;
    if (acc) begin
      have_op = 1'b0;
      issued++;
    end
  endtask

  // Single isolated operation: checks acceptance, latency and result.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.g_in      = v.g;
    bus.p_in      = v.p;
    bus.cin       = v.cin;
    #1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd5);
    chk({tag, "_sum"}, 32'(bus.sum), 32'(v.sum));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(v.cout));
`ifdef KS_OVF_EN
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(v.ovf));
`endif
    @(posedge clk); #1;
    chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl [11];
    vec_t post;
    int   guard;

    //             g         p         cin   sum       cout  ovf
    tbl[0]  = '{16'h0220, 16'h5115, 1'b0, 16'h5555, 1'b0, 1'b0}; // 1234+4321
    tbl[1]  = '{16'h0001, 16'hFFFE, 1'b0, 16'h0000, 1'b1, 1'b0}; // FFFF+0001
    tbl[2]  = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0}; // FFFF+0000+1
    tbl[3]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0}; // 0+0
    tbl[4]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0}; // 0+0+1
    tbl[5]  = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0}; // FFFF+FFFF+1
    tbl[6]  = '{16'h0001, 16'h00FE, 1'b0, 16'h0100, 1'b0, 1'b0}; // 00FF+0001
    tbl[7]  = '{16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1}; // 8000+8000
    tbl[8]  = '{16'h0001, 16'h0001, 1'b0, 16'h0003, 1'b0, 1'b0}; // g&p=1 on bit 0
    tbl[9]  = '{16'h0001, 16'h7FFE, 1'b0, 16'h8000, 1'b0, 1'b1}; // 7FFF+0001
    tbl[10] = '{16'h0001, 16'h0000, 1'b0, 16'h0002, 1'b0, 1'b0}; // 0001+0001

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.g_in      = '0;
    bus.p_in      = '0;
    bus.cin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
`ifdef KS_OVF_EN
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready_release", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back stream, out_ready held high.
    issued = 0; received = 0; first_out = -1; last_out = -1; guard = 0;
    while (issued < 20 && guard < 40) begin
      drive_step(1'b1, 1'b1);
      chk("stream_in_ready", 32'(last_in_ready), 32'd1);
      guard++;
    end
    guard = 0;
    while (expq.size() > 0 && guard < 40) begin
      drive_step(1'b0, 1'b1);
      guard++;
    end
    chk("stream_count", 32'(received), 32'd20);
    chk("stream_rate", 32'(last_out - first_out), 32'd19);

    // Backpressure: consumer stalled for 12 cycles.
    issued = 0; received = 0;
    for (int i = 0; i < 12; i++) drive_step(1'b1, 1'b0);
    chk("stall_accepted", 32'(issued), 32'd5);
    chk("stall_in_ready", 32'(last_in_ready), 32'd0);
    chk("stall_held", 32'(expq.size()), 32'd5);
    chk("stall_no_output", 32'(received), 32'd0);

    // Release with out_ready toggling; the pending sixth op is still offered.
    received = 0; guard = 0;
    while ((have_op || expq.size() > 0) && guard < 60) begin
      drive_step(1'b0, guard[0]);
      guard++;
    end
    chk("release_count", 32'(received), 32'd6);
    chk("release_issued", 32'(issued), 32'd6);
    chk("release_empty", 32'(expq.size()), 32'd0);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) drive_step(1'b1, 1'b1);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_sum", 32'(bus.sum), 32'd0);
    chk("midrst_cout", 32'(bus.cout), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready_release", 32'(bus.in_ready), 32'd1);
    expq.delete();
    have_op = 1'b0; prev_hold = 1'b0; received = 0;
    for (int i = 0; i < 8; i++) drive_step(1'b0, 1'b1);
    chk("midrst_no_stale", 32'(received), 32'd0);
    post = tbl[0];
    run_vec(post, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ks_prefix_pipe.md
# ks_prefix_pipe

- Pipelined Kogge-Stone prefix network and sum stage.
- Sits directly downstream of the per-bit generate/propagate (GP) cells of the Kogge-Stone adder.
- Consumes the WIDTH-bit generate (G = A&B) and propagate (P = A^B) vectors plus carry-in; produces the registered sum and carry-out.
- Accepts one operation per cycle behind a valid/ready handshake and stalls cleanly under backpressure.

## Interface
Parameters:
- WIDTH, 16, operand width; power of two, ≥4.
- LEVELS, $clog2(WIDTH), number of prefix levels; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; one clock, reset is synchronous and active-low.
- in_valid  input  1  g_in/p_in/cin hold a valid operation.
- in_ready  output  1  block accepts the operation this cycle.
- g_in  input  WIDTH  per-bit generate from the GP cells.
- p_in  input  WIDTH  per-bit propagate (XOR form) from the GP cells.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  registered sum.
- cout  output  1  registered carry-out.
- ovf  output  1  signed overflow; present only with KS_OVF_EN.

## Operation
- Pipeline stages S0..S_LEVELS, each with a valid bit.
- S0 captures G, P, cin and the original P.
  - Bit 0 is folded with carry-in: G0' = g0 | (p0 & cin).
- Stage Sk (k = 1..LEVELS) applies the prefix operator (G,P)∘(G',P') = (G | P&G', P&P') at distance 2^(k-1).
  - Bits i < 2^(k-1) pass through unchanged.
  - The original P and cin travel alongside the prefix data.
- The final stage computes:
  - carry c[i] = group-G[i] (carry out of bit i).
  - sum[0] = p[0]^cin; sum[i] = p[i]^c[i-1].
  - cout = c[WIDTH-1].
- The final stage registers sum and cout.
- Results always leave in acceptance order.
- Behaviour is fully defined for any g_in/p_in, including g&p = 1 on a bit; no checking is performed.

## Timing
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - in_valid and data must be held stable until accepted; out_valid and data are held stable until taken.
- Latency: LEVELS+1 cycles from input acceptance to out_valid (5 for WIDTH=16).
- Throughput: one operation per cycle when out_ready stays high.
- Stall rule:
  - Stage k advances when it is empty, or when stage k+1 advances or is empty.
  - The final stage advances when out_valid=0 or out_ready=1.
  - in_ready = !valid[S0] or S0 advances; bubbles collapse.
  - in_ready depends combinationally on out_ready.
- Full: with out_ready held low, at most LEVELS+1 operations are held; in_ready then reads 0.
  - No result is dropped, duplicated or overwritten.
- Simultaneous in/out transfer on a full pipeline is permitted and keeps occupancy constant.
- Reset (rst_n=0 sampled at edge):
  - All valid bits, data registers, sum, cout and ovf are cleared to 0.
  - out_valid=0.
  - in_ready=0 while rst_n is low; in_ready=1 the first cycle after release.
- Reset mid-operation discards all in-flight operations; nothing emerges afterward.

## Configuration
- KS_OVF_EN defined:
  - Port ovf is present.
  - ovf = c[WIDTH-1] ^ c[WIDTH-2], registered with sum and stalled identically.
  - Reset value 0.
- KS_OVF_EN undefined:
  - ovf port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- WIDTH=16, g_in=0x0220, p_in=0x5115, cin=0 (0x1234+0x4321) -> after 5 cycles sum=0x5555, cout=0, out_valid=1.
- g_in=0x0001, p_in=0xFFFE, cin=0 (0xFFFF+1) -> sum=0x0000, cout=1; and g_in=0x0000, p_in=0xFFFF, cin=1 -> sum=0x0000, cout=1.
- Back-to-back stream of 20 random operand pairs with out_ready=1 -> one result per cycle, matching A+B+cin, in order; in_ready constantly 1.
- out_ready=0 for 12 cycles while in_valid=1 -> exactly 5 operations accepted, then in_ready=0; on release, all results emerge in order with no loss; out_ready toggling every cycle -> data still stable while out_valid & !out_ready.
- rst_n=0 for one cycle with 3 operations in flight -> next cycle out_valid=0, sum=0, cout=0; no stale result ever appears; a new operation completes after 5 cycles.
- KS_OVF_EN defined, g_in=0x0001, p_in=0x7FFE, cin=0 (0x7FFF+1) -> sum=0x8000, cout=0, ovf=1; 0x0001+0x0001 -> ovf=0.
